mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single-port 16-bit data RAM behind the memory stage. It shares the RAM between the CPU memory stage (requester 0) and an external loader/IO port (requester 1). It also raises the pipeline stall that holds the Execute/Memory register until the CPU access completes. It sits between the Execute/Memory register outputs (ALU result as address, store data, write-mem flag) and the RAM, ahead of the Memory/Writeback register.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_age_counter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-RAM port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int MEM_DEPTH_DEF = 1024;
  localparam int MAX_WAIT_DEF  = 4;

  // Sequencer states: arbitrate in IDLE, answer the owner in RESP_*.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESP_CPU = 2'd1,
    RESP_EXT = 2'd2
  } state_t;

  // Which requester owns the RAM port in the grant cycle.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating age counter: counts how many contests the ext port has lost
// in a row, so it can be promoted once the count reaches MAX_WAIT.
module arb_age_counter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat_o = (cnt_q == CNT_W'(MAX_WAIT));
  assign cnt_o = cnt_q;

  // Next count: clear wins over increment, increment stops at MAX_WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                cnt_d = '0;
    else if (inc_i && !sat_o) cnt_d = cnt_q + 1'b1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data RAM behind the
// memory stage. Requester 0 is the CPU memory stage, requester 1 the
// external loader port. Each access takes a grant cycle (IDLE) followed by
// a response cycle (RESP_*), and the CPU is stalled until its done pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // CPU memory stage (requester 0)
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              stall,
  // External loader / IO port (requester 1)
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_done,
  output logic              ext_err,
  // RAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  // Depth widened by one bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

  state_t state_q, state_d;
  logic   we_q,  we_d;
  logic   err_q, err_d;
  logic [DATA_W-1:0] cpu_hold_q, ext_hold_q;

  logic idle, resp_cpu, resp_ext;
  logic cpu_win, ext_win, grant;
  owner_t owner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;
  logic              age_sat;
  logic [CNT_W-1:0]  wait_cnt;

  // Nothing is granted or answered while reset is held.
  assign idle     = (state_q == IDLE)     && !rst;
  assign resp_cpu = (state_q == RESP_CPU) && !rst;
  assign resp_ext = (state_q == RESP_EXT) && !rst;

  // CPU has priority unless the ext port has aged out while still asking.
  assign cpu_win = idle && cpu_req && !(ext_req && age_sat);
  assign ext_win = idle && ext_req && !cpu_win;
  assign grant   = cpu_win || ext_win;
  assign owner   = ext_win ? OWN_EXT : OWN_CPU;

  arb_age_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_age (
    .clk   (clk),
    .rst   (rst),
    .inc_i (idle && ext_req && cpu_win),
    .clr_i (idle && (ext_win || !ext_req)),
    .cnt_o (wait_cnt),
    .sat_o (age_sat)
  );

  // Grant mux: route the winner's request onto the RAM port in the grant cycle.
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (owner == OWN_EXT) begin
      sel_we    = ext_we;
      sel_addr  = ext_addr;
      sel_wdata = ext_wdata;
    end
    sel_in_range = ({1'b0, sel_addr} < DEPTH_EXT);
  end

  // Out-of-range accesses never touch the RAM; the bus idles at zero.
  assign mem_en    = grant && sel_in_range;
  assign mem_we    = mem_en && sel_we;
  assign mem_addr  = mem_en ? sel_addr  : '0;
  assign mem_wdata = mem_en ? sel_wdata : '0;

  // Next-state logic: one grant cycle, one response cycle, back to IDLE.
  always_comb begin
    state_d = IDLE;
    we_d    = we_q;
    err_d   = err_q;
    if (state_q == IDLE) begin
      if (cpu_win)      state_d = RESP_CPU;
      else if (ext_win) state_d = RESP_EXT;
      if (grant) begin
        we_d  = sel_we;
        err_d = !sel_in_range;
      end
    end
  end

  // Sequencer state and the access attributes latched at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // Read-data hold registers: only successful loads refresh them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_hold_q <= '0;
      ext_hold_q <= '0;
    end else begin
      if (resp_cpu && !err_q && !we_q) cpu_hold_q <= mem_rdata;
      if (resp_ext && !err_q && !we_q) ext_hold_q <= mem_rdata;
    end
  end

  // Read-data outputs: live RAM data on a load response, zero on error, else held.
  always_comb begin
    cpu_rdata = cpu_hold_q;
    ext_rdata = ext_hold_q;
    if (rst) begin
      cpu_rdata = '0;
      ext_rdata = '0;
    end else begin
      if (resp_cpu) begin
        if (err_q)      cpu_rdata = '0;
        else if (!we_q) cpu_rdata = mem_rdata;
      end
      if (resp_ext) begin
        if (err_q)      ext_rdata = '0;
        else if (!we_q) ext_rdata = mem_rdata;
      end
    end
  end

  assign cpu_done = resp_cpu;
  assign cpu_err  = resp_cpu && err_q;
  assign ext_done = resp_ext;
  assign ext_err  = resp_ext && err_q;
  assign stall    = cpu_req && !cpu_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int MW    = 4;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_done, cpu_err, stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ext_req, ext_we, ext_done, ext_err;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] cpu_hold;
  logic [DW-1:0] ext_hold;

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_DEPTH (DEPTH),
    .MAX_WAIT  (MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_err   (cpu_err),
    .stall     (stall),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_done  (ext_done),
    .ext_err   (ext_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, synchronous read, read-before-write.
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete single access on the chosen port, starting in an IDLE cycle.
  task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
    string pn;
    bit    err;
    pn  = port ? "ext" : "cpu";
    err = (int'(addr) >= DEPTH);
    if (!port) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    end
    #1;
    // grant cycle
    check_eq($sformatf("%s_grant_en", pn), 32'(mem_en), 32'(!err));
    if (!err) begin
      check_eq($sformatf("%s_grant_addr", pn), 32'(mem_addr), 32'(addr));
      check_eq($sformatf("%s_grant_we", pn), 32'(mem_we), 32'(we));
      if (we) check_eq($sformatf("%s_grant_wdata", pn), 32'(mem_wdata), 32'(wdata));
    end
    check_eq($sformatf("%s_grant_stall", pn), 32'(stall), 32'(!port));
    step();
    // response cycle
    if (!port) begin
      check_eq("cpu_done", 32'(cpu_done), 32'd1);
      check_eq("cpu_err", 32'(cpu_err), 32'(err));
      check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
      check_eq("cpu_resp_stall", 32'(stall), 32'd0);
      check_eq("cpu_other_done", 32'(ext_done), 32'd0);
      check_eq("cpu_other_rdata", 32'(ext_rdata), 32'(ext_hold));
      cpu_req = 1'b0;
      if (!err && !we) cpu_hold = exp_rd;
    end else begin
      check_eq("ext_done", 32'(ext_done), 32'd1);
      check_eq("ext_err", 32'(ext_err), 32'(err));
      check_eq("ext_rdata", 32'(ext_rdata), 32'(exp_rd));
      check_eq("ext_other_done", 32'(cpu_done), 32'd0);
      check_eq("ext_other_rdata", 32'(cpu_rdata), 32'(cpu_hold));
      ext_req = 1'b0;
      if (!err && !we) ext_hold = exp_rd;
    end
    step();
    // idle cycle: nothing pending, data held
    check_eq($sformatf("%s_idle_en", pn), 32'(mem_en), 32'd0);
    check_eq($sformatf("%s_idle_stall", pn), 32'(stall), 32'd0);
    check_eq($sformatf("%s_idle_cpu_rdata", pn), 32'(cpu_rdata), 32'(cpu_hold));
    check_eq($sformatf("%s_idle_ext_rdata", pn), 32'(ext_rdata), 32'(ext_hold));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cpu_cnt;
    int ext_at;
    bit ext_seen;
    cpu_hold = '0;
    ext_hold = '0;

    // Reset held with both requesters asking
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0020; ext_wdata = 16'h0AAA;
    repeat (3) step();
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_cpu_done", 32'(cpu_done), 32'd0);
    check_eq("rst_ext_done", 32'(ext_done), 32'd0);
    check_eq("rst_cpu_err", 32'(cpu_err), 32'd0);
    check_eq("rst_ext_err", 32'(ext_err), 32'd0);
    check_eq("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check_eq("rst_ext_rdata", 32'(ext_rdata), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd1);
    check_eq("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);

    // First IDLE after reset: CPU wins the contest
    rst = 1'b0;
    #1;
    check_eq("first_grant_en", 32'(mem_en), 32'd1);
    check_eq("first_grant_addr", 32'(mem_addr), 32'h10);
    check_eq("first_grant_we", 32'(mem_we), 32'd1);
    check_eq("first_grant_wdata", 32'(mem_wdata), 32'hBEEF);
    check_eq("first_grant_stall", 32'(stall), 32'd1);
    step();
    check_eq("first_cpu_done", 32'(cpu_done), 32'd1);
    check_eq("first_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check_eq("first_ext_done", 32'(ext_done), 32'd0);
    check_eq("first_resp_stall", 32'(stall), 32'd0);
    cpu_req = 1'b0;
    step();
    // ext, having lost once, is granted now
    check_eq("second_wait_cnt", 32'(dut.wait_cnt), 32'd1);
    check_eq("second_grant_en", 32'(mem_en), 32'd1);
    check_eq("second_grant_addr", 32'(mem_addr), 32'h20);
    check_eq("second_grant_stall", 32'(stall), 32'd0);
    step();
    check_eq("second_ext_done", 32'(ext_done), 32'd1);
    check_eq("second_ext_rdata", 32'(ext_rdata), 32'd0);
    check_eq("second_cpu_done", 32'(cpu_done), 32'd0);
    ext_req = 1'b0;
    step();

    // CPU load back the stored word
    access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

    // Out-of-range load: error, zero data, hold keeps 0xBEEF
    access(1'b0, 1'b0, 16'd1024, 16'h0000, 16'h0000);

    // Alternating single requests, including the last valid address
    access(1'b0, 1'b1, 16'd0,    16'h1111, 16'hBEEF);
    access(1'b1, 1'b1, 16'd1023, 16'h2222, 16'h0000);
    access(1'b0, 1'b0, 16'd0,    16'h0000, 16'h1111);
    access(1'b1, 1'b0, 16'd1023, 16'h0000, 16'h2222);

    // Fairness: continuous CPU loads with ext also asking
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'd1023;
    cpu_cnt  = 0;
    ext_at   = -1;
    ext_seen = 1'b0;
    for (int cyc = 0; cyc < 60 && cpu_cnt < 10; cyc++) begin
      step();
      if (cpu_done) begin
        cpu_cnt++;
        check_eq("fair_cpu_rdata", 32'(cpu_rdata), 32'h1111);
      end
      if (ext_done) begin
        ext_seen = 1'b1;
        ext_at   = cpu_cnt;
        check_eq("fair_ext_rdata", 32'(ext_rdata), 32'h2222);
        ext_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    check_eq("fair_cpu_count", 32'(cpu_cnt), 32'd10);
    check_eq("fair_ext_seen", 32'(ext_seen), 32'd1);
    check_eq("fair_ext_after", 32'(ext_at), 32'd4);
    step();
    check_eq("fair_idle_en", 32'(mem_en), 32'd0);

    // Reset landing in the RESP_EXT cycle of an ext store
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'd5; ext_wdata = 16'h1234;
    #1;
    check_eq("rstx_grant_en", 32'(mem_en), 32'd1);
    step();
    rst = 1'b1;
    ext_req = 1'b0;
    #1;
    check_eq("rstx_no_done", 32'(ext_done), 32'd0);
    check_eq("rstx_ext_rdata", 32'(ext_rdata), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check_eq("rstx_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("rstx_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    check_eq("rstx_ext_done", 32'(ext_done), 32'd0);
    check_eq("rstx_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check_eq("rstx_ext_rdata_after", 32'(ext_rdata), 32'd0);
    cpu_hold = '0;
    ext_hold = '0;
    access(1'b1, 1'b0, 16'd5, 16'h0000, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
